fu_issue_ctrl: RTL and testbench
================================

// Module: fu_issue_ctrl
// PURPOSE
//  Issue/sequencing front end for one functionalUnit lane. Accepts decoded ALU ops over
//  valid/ready, drives the FU's enable/alu_op/alu_A/alu_B and holds them stable for the
//  op's latency. Captures alu_out and presents result + dest tag to writeback over valid/ready.
//  One instance per thread lane, between operand fetch and register writeback.
// PARAMETERS
//  MACHINE_WIDTH  32  datapath width; matches harmonica_cfg
//  REG_BITS       6   destination register tag width
//  MUL_LAT        4   FU cycles for mul (op 5'b01000); >=1
//  DIV_LAT        8   FU cycles for div/mod (5'b01001, 5'b01010); >=1
// PORTS
//  clk           in   1         clock
//  reset         in   1         synchronous, active-high reset
//  in_valid      in   1         upstream op valid
//  in_ready      out  1         ctrl can accept op
//  in_op         in   5         ALU opcode (HARP encoding)
//  in_a          in   MW        operand A
//  in_b          in   MW        operand B
//  in_rd         in   REG_BITS  destination tag
//  fu_enable     out  1         FU enable
//  fu_alu_op     out  5         to FU alu_op
//  fu_fp_ctl     out  1         to FU fp_ctl; constant 0
//  fu_alu_a      out  MW        to FU alu_A
//  fu_alu_b      out  MW        to FU alu_B
//  fu_mem_read   out  1         constant 0
//  fu_mem_write  out  1         constant 0
//  fu_alu_out    in   MW        FU result
//  out_valid     out  1         result valid
//  out_ready     in   1         writeback accepts
//  out_data      out  MW        result
//  out_rd        out  REG_BITS  echoed dest tag
//  out_div_zero  out  1         div/mod-by-zero flag (see CONFIGURATION)
//  busy          out  1         state != IDLE
// BEHAVIOUR
//  - Single clock clk; reset synchronous, active-high. All state changes on posedge clk.
//  - FSM IDLE -> EXEC -> DRAIN.
//  - Reset: state=IDLE. out_valid, fu_enable, out_div_zero, busy = 0. Op/operand/result/tag
//    regs and counter = 0. in_ready forced 0 while reset is high.
//  - in_ready (comb) = !reset && (IDLE || (DRAIN && out_ready)).
//  - Accept = in_valid && in_ready. Latches op/a/b/rd. cnt = lat(op)-1, where
//    lat = MUL_LAT (mul), DIV_LAT (div/mod), 1 (all other opcodes, incl. undefined).
//    Next state EXEC.
//  - EXEC: fu_enable=1. fu_alu_op/a/b driven from latched regs, stable the whole state.
//    If cnt != 0, decrement. If cnt == 0, latch fu_alu_out into out_data, then go to DRAIN.
//  - fu_alu_* hold the last latched values outside EXEC. Only fu_enable qualifies them.
//  - DRAIN: out_valid=1. out_data/out_rd/out_div_zero held stable until out_ready.
//    - out_ready && !in_valid: go to IDLE.
//    - out_ready && in_valid: accept the new op the same cycle and go to EXEC (no bubble).
//  - Latency: op accepted at edge T gives out_valid high from cycle T+1+lat.
//    Throughput is 1 op per (lat+1) cycles under continuous out_ready.
//  - Undefined opcodes pass through. Result is whatever the FU returns (its default is 0).
//  - Reset in EXEC or DRAIN aborts the op. No out_valid is produced for it.
//  - cnt width = $clog2(max(MUL_LAT,DIV_LAT)+1).
// CONFIGURATION
//  DIV_ZERO_TRAP_EN defined:
//  - On accept of div/mod with in_b==0: skip EXEC (fu_enable stays 0).
//  - Next state is DRAIN with out_data=0, out_div_zero=1. out_valid is high from T+1.
//  - out_div_zero is 0 for all other results.
//  DIV_ZERO_TRAP_EN undefined:
//  - out_div_zero tied 0. Div/mod by zero is dispatched normally with DIV_LAT latency.
// TESTING
//  1. add: op 5'b00110, a=5, b=7, rd=3, accepted at T, out_ready=1
//     -> fu_enable high only at T+1; out_valid at T+2; out_data=12; out_rd=3.
//  2. mul 3*4 with MUL_LAT=4 -> fu_enable high T+1..T+4, operands stable;
//     out_valid at T+5; out_data=12.
//  3. Backpressure: hold out_ready=0 for 3 cycles -> out_valid/out_data/out_rd stable, in_ready=0.
//     Then out_ready=1 with in_valid sub 10-3 -> accepted that cycle; next out_data=7.
//  4. Reset asserted mid-EXEC of div 100/7 -> next cycle state IDLE, fu_enable=0, out_valid=0.
//     in_ready=1 after reset drops; no stale result ever appears.
//  5. div 7/0 -> with DIV_ZERO_TRAP_EN: out_valid at T+1, out_data=0, out_div_zero=1, fu_enable never high.
//     Without it: out_valid at T+1+DIV_LAT, out_div_zero=0.
//  6. Back-to-back iszero(0) then not(0) with out_ready=1, in_valid continuous
//     -> results 1 then all-ones; each issued 2 cycles apart.

Source files
------------

// File: rtl/fu_issue_ctrl.sv
// rtl/fu_issue_ctrl.sv - issue/sequencing front end for one functional-unit lane
// Optional build macro: DIV_ZERO_TRAP_EN (div/mod by zero bypasses the FU and flags out_div_zero)
module fu_issue_ctrl #(
    parameter int MACHINE_WIDTH = 32,
    parameter int REG_BITS      = 6,
    parameter int MUL_LAT       = 4,
    parameter int DIV_LAT       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_op,
    input  logic [MACHINE_WIDTH-1:0] in_a,
    input  logic [MACHINE_WIDTH-1:0] in_b,
    input  logic [REG_BITS-1:0]      in_rd,
    output logic                     fu_enable,
    output logic [4:0]               fu_alu_op,
    output logic                     fu_fp_ctl,
    output logic [MACHINE_WIDTH-1:0] fu_alu_a,
    output logic [MACHINE_WIDTH-1:0] fu_alu_b,
    output logic                     fu_mem_read,
    output logic                     fu_mem_write,
    input  logic [MACHINE_WIDTH-1:0] fu_alu_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MACHINE_WIDTH-1:0] out_data,
    output logic [REG_BITS-1:0]      out_rd,
    output logic                     out_div_zero,
    output logic                     busy
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01001;
    localparam logic [4:0] OP_MOD = 5'b01010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [4:0]               op_q, op_d;
    logic [MACHINE_WIDTH-1:0] a_q, a_d;
    logic [MACHINE_WIDTH-1:0] b_q, b_d;
    logic [REG_BITS-1:0]      rd_q, rd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [MACHINE_WIDTH-1:0] data_q, data_d;
    logic                     dz_q, dz_d;

    logic                     accept;
    logic                     is_mul;
    logic                     is_div;
    logic                     trap;
    logic [CNT_W-1:0]         lat_m1;

    always_comb begin
        in_ready = !reset && ((state_q == S_IDLE) || ((state_q == S_DRAIN) && out_ready));
        accept   = in_valid && in_ready;
        is_mul   = (in_op == OP_MUL);
        is_div   = (in_op == OP_DIV) || (in_op == OP_MOD);

        if (is_mul) begin
            lat_m1 = CNT_W'(MUL_LAT - 1);
        end else if (is_div) begin
            lat_m1 = CNT_W'(DIV_LAT - 1);
        end else begin
            lat_m1 = '0;
        end

`ifdef DIV_ZERO_TRAP_EN
        trap = is_div && (in_b == '0);
`else
        trap = 1'b0;
`endif

        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d  = fu_alu_out;
                    dz_d    = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accept in DRAIN overrides the return to IDLE, giving back-to-back issue.
        if (accept) begin
            op_d  = in_op;
            a_d   = in_a;
            b_d   = in_b;
            rd_d  = in_rd;
            cnt_d = lat_m1;
            if (trap) begin
                data_d  = '0;
                dz_d    = 1'b1;
                state_d = S_DRAIN;
            end else begin
                state_d = S_EXEC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dz_q    <= dz_d;
        end
    end

    assign fu_enable    = (state_q == S_EXEC);
    assign fu_alu_op    = op_q;
    assign fu_alu_a     = a_q;
    assign fu_alu_b     = b_q;
    assign fu_fp_ctl    = 1'b0;
    assign fu_mem_read  = 1'b0;
    assign fu_mem_write = 1'b0;
    assign out_valid    = (state_q == S_DRAIN);
    assign out_data     = data_q;
    assign out_rd       = rd_q;
    assign out_div_zero = dz_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb/tb_fu_issue_ctrl.sv - randomized bench for fu_issue_ctrl against a transaction-level reference model
module tb_fu_issue_ctrl;
    localparam int MW  = 32;
    localparam int RB  = 6;
    localparam int MUL = 4;
    localparam int DIV = 8;

    localparam logic [4:0] OP_ISZ = 5'b00001;
    localparam logic [4:0] OP_NOT = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00110;
    localparam logic [4:0] OP_SUB = 5'b00111;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01001;
    localparam logic [4:0] OP_MOD = 5'b01010;
    localparam logic [4:0] OP_UND = 5'b11111;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [MW-1:0] in_a;
    logic [MW-1:0] in_b;
    logic [RB-1:0] in_rd;
    logic          fu_enable;
    logic [4:0]    fu_alu_op;
    logic          fu_fp_ctl;
    logic [MW-1:0] fu_alu_a;
    logic [MW-1:0] fu_alu_b;
    logic          fu_mem_read;
    logic          fu_mem_write;
    logic [MW-1:0] fu_alu_out;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_data;
    logic [RB-1:0] out_rd;
    logic          out_div_zero;
    logic          busy;

    fu_issue_ctrl #(
        .MACHINE_WIDTH(MW), .REG_BITS(RB), .MUL_LAT(MUL), .DIV_LAT(DIV)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .fu_enable(fu_enable), .fu_alu_op(fu_alu_op), .fu_fp_ctl(fu_fp_ctl),
        .fu_alu_a(fu_alu_a), .fu_alu_b(fu_alu_b),
        .fu_mem_read(fu_mem_read), .fu_mem_write(fu_mem_write),
        .fu_alu_out(fu_alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_div_zero(out_div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] fu_func(input logic [4:0] op, input logic [MW-1:0] a, input logic [MW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? '1 : a / b;
            OP_MOD:  return (b == 0) ? a : a % b;
            OP_ISZ:  return (a == 0) ? 32'd1 : 32'd0;
            OP_NOT:  return ~a;
            default: return '0;
        endcase
    endfunction

    always_comb fu_alu_out = fu_func(fu_alu_op, fu_alu_a, fu_alu_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Reference: at most one op in flight, characterised by when it was accepted
    // and how many edges until its result is due.
    bit            have_op = 1'b0;
    int            edge_n  = 0;
    int            acc_edge;
    int            m_lat;
    logic [4:0]    m_op;
    logic [MW-1:0] m_a, m_b, m_res;
    logic [RB-1:0] m_rd;
    logic          m_dz;

    function automatic bit is_trap(input logic [4:0] op, input logic [MW-1:0] b);
`ifdef DIV_ZERO_TRAP_EN
        return ((op == OP_DIV) || (op == OP_MOD)) && (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lat_of(input logic [4:0] op, input logic [MW-1:0] b);
        if (is_trap(op, b)) return 0;
        if (op == OP_MUL) return MUL;
        if ((op == OP_DIV) || (op == OP_MOD)) return DIV;
        return 1;
    endfunction

    task automatic step(input logic rst, input logic iv, input logic [4:0] op,
                        input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input logic [RB-1:0] rd, input logic ordy);
        logic ov_e, en_e, ir_e, acc, dlv;
        ov_e = have_op && (edge_n >= acc_edge + m_lat);
        en_e = have_op && (edge_n <  acc_edge + m_lat);
        chk("out_valid", out_valid, ov_e);
        chk("fu_enable", fu_enable, en_e);
        chk("busy", busy, have_op);
        if (ov_e) begin
            chk("out_data", out_data, m_res);
            chk("out_rd", out_rd, m_rd);
            chk("out_div_zero", out_div_zero, m_dz);
        end
        if (en_e) begin
            chk("fu_alu_op", fu_alu_op, m_op);
            chk("fu_alu_a", fu_alu_a, m_a);
            chk("fu_alu_b", fu_alu_b, m_b);
        end
        reset = rst; in_valid = iv; in_op = op; in_a = a; in_b = b; in_rd = rd; out_ready = ordy;
        #1;
        ir_e = !rst && (!have_op || (ov_e && ordy));
        chk("in_ready", in_ready, ir_e);
        acc = iv && ir_e;
        dlv = ov_e && ordy;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            have_op = 1'b0;
        end else begin
            if (dlv) have_op = 1'b0;
            if (acc) begin
                have_op  = 1'b1;
                acc_edge = edge_n;
                m_op = op; m_a = a; m_b = b; m_rd = rd;
                m_lat = lat_of(op, b);
                m_dz  = is_trap(op, b);
                m_res = m_dz ? '0 : fu_func(op, a, b);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, '0, '0, '0, ordy);
    endtask

    logic [4:0] op_tab [8];

    initial begin
        op_tab = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_ISZ, OP_NOT, OP_UND};
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_fu_enable", fu_enable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_div_zero", out_div_zero, 1'b0);
        chk("rst_alu_a", fu_alu_a, 0);
        chk("rst_alu_op", fu_alu_op, 0);
        chk("fp_ctl", fu_fp_ctl, 1'b0);
        chk("mem_read", fu_mem_read, 1'b0);
        chk("mem_write", fu_mem_write, 1'b0);

        step(1'b0, 1'b1, OP_ADD, 32'd5, 32'd7, 6'd3, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b1, OP_MUL, 32'd3, 32'd4, 6'd9, 1'b1);
        idle(6, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b1, OP_SUB, 32'd10, 32'd3, 6'd1, 1'b1);
        idle(4, 1'b1);
        step(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7, 6'd5, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 1'b0, 5'd0, '0, '0, '0, 1'b1);
        idle(12, 1'b1);
        step(1'b0, 1'b1, OP_DIV, 32'd7, 32'd0, 6'd2, 1'b1);
        idle(12, 1'b1);
        step(1'b0, 1'b1, OP_ISZ, 32'd0, 32'd0, 6'd4, 1'b1);
        step(1'b0, 1'b1, OP_NOT, 32'd0, 32'd0, 6'd6, 1'b1);
        step(1'b0, 1'b1, OP_NOT, 32'd0, 32'd0, 6'd6, 1'b1);
        idle(4, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic [MW-1:0] b;
            b = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) < 7,
                 op_tab[$urandom_range(0, 7)],
                 MW'($urandom), b, RB'($urandom),
                 $urandom_range(0, 9) < 7);
        end
        idle(12, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
